edge_frame_sched: RTL and testbench

- Frame-level sequencer in front of the 3x3 window generator / Sobel pipeline.
- Arms on a software start and locks onto the next full camera frame.
- Forwards that frame's sync and pixel stream, checks its geometry, then generates the post-frame flush line that drains the line buffers.
- Reports done and error status to the control registers.

---
 rtl/edge_frame_sched.sv | 176 +++++++++++++++++
 tb/tb_edge_frame_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_sched.sv
// Frame sequencer ahead of the 3x3 window / Sobel pipeline: arms on cfg_start, forwards one
// camera frame, checks its geometry and emits the flush line. Watchdog: EDGE_FRAME_SCHED_TIMEOUT_EN.
module edge_frame_sched #(
  parameter logic [15:0] IMG_HDISP   = 16'd640,
  parameter logic [15:0] IMG_VDISP   = 16'd480,
  parameter logic [15:0] DELAY_NUM   = 16'd10,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic       cfg_abort,
  input  logic       cfg_continuous,
  input  logic       in_vsync,
  input  logic       in_href,
  input  logic [7:0] in_gray,
  output logic       out_vsync,
  output logic       out_href,
  output logic [7:0] out_gray,
  output logic       flush_href,
  output logic       busy,
  output logic       done,
  output logic       err_hlen,
  output logic       err_vlen,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_ACTIVE,
    S_GAP,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        vs_d;
  logic        href_d;
  logic [15:0] hcnt;
  logic [15:0] vcnt;
  logic [15:0] dcnt;
  logic [15:0] fcnt;

  logic        vs_rise;
  logic        vs_fall;
  logic        href_fall;
  logic        line_end;
  logic        frame_full;
  logic        start_accept;
  logic        timeout_hit;
  logic [15:0] vcnt_inc;
  logic [15:0] vcnt_eff;

  assign vs_rise      = in_vsync & ~vs_d;
  assign vs_fall      = ~in_vsync & vs_d;
  assign href_fall    = ~in_href & href_d;
  assign line_end     = (state == S_ACTIVE) & href_fall;
  assign vcnt_inc     = vcnt + 16'd1;
  assign vcnt_eff     = line_end ? vcnt_inc : vcnt;
  assign frame_full   = line_end & (vcnt_inc == IMG_VDISP);
  assign start_accept = (state == S_IDLE) & cfg_start & ~cfg_abort;

  // A vsync fall that coincides with a line end still counts that line before judging the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cfg_start) state_nxt = S_WAIT_VS;
      S_WAIT_VS: if (vs_rise) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (frame_full)
          state_nxt = S_GAP;
        else if (vs_fall)
          state_nxt = (vcnt_eff == 16'd0) ? S_DONE : S_GAP;
      end
      S_GAP:     if (dcnt + 16'd1 >= DELAY_NUM) state_nxt = S_FLUSH;
      S_FLUSH:   if (fcnt + 16'd1 >= IMG_HDISP) state_nxt = S_DONE;
      S_DONE:    state_nxt = cfg_continuous ? S_WAIT_VS : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (timeout_hit) state_nxt = S_IDLE;
    if (cfg_abort)   state_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so abort/timeout silence them one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vs_d       <= 1'b0;
      href_d     <= 1'b0;
      hcnt       <= 16'd0;
      vcnt       <= 16'd0;
      dcnt       <= 16'd0;
      fcnt       <= 16'd0;
      out_vsync  <= 1'b0;
      out_href   <= 1'b0;
      out_gray   <= 8'd0;
      flush_href <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_hlen   <= 1'b0;
      err_vlen   <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_d       <= in_vsync;
      href_d     <= in_href;
      out_gray   <= in_gray;
      out_href   <= in_href & (state == S_ACTIVE) & (state_nxt != S_IDLE);
      out_vsync  <= ((state == S_ACTIVE) | (state == S_GAP) | (state == S_FLUSH)) &
                    (state_nxt != S_IDLE);
      flush_href <= (state_nxt == S_FLUSH);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);

      if (state == S_ACTIVE) begin
        if (href_fall)
          hcnt <= 16'd0;
        else if (in_href)
          hcnt <= hcnt + 16'd1;
        if (line_end)
          vcnt <= vcnt_inc;
      end else begin
        hcnt <= 16'd0;
        vcnt <= 16'd0;
      end

      dcnt <= (state == S_GAP)   ? dcnt + 16'd1 : 16'd0;
      fcnt <= (state == S_FLUSH) ? fcnt + 16'd1 : 16'd0;

      if (start_accept) begin
        err_hlen <= 1'b0;
        err_vlen <= 1'b0;
      end else begin
        if (line_end && (hcnt != IMG_HDISP))
          err_hlen <= 1'b1;
        if ((state == S_ACTIVE) && vs_fall && !frame_full)
          err_vlen <= 1'b1;
      end
    end
  end

`ifdef EDGE_FRAME_SCHED_TIMEOUT_EN
  logic [31:0] wdog;
  logic        wdog_zone;
  logic        wdog_entry;
  logic        href_rise;

  assign wdog_zone   = (state == S_WAIT_VS) | (state == S_ACTIVE);
  assign wdog_entry  = ((state_nxt == S_WAIT_VS) | (state_nxt == S_ACTIVE)) & (state_nxt != state);
  assign href_rise   = in_href & ~href_d;
  assign timeout_hit = wdog_zone & (wdog == TIMEOUT_CYC - 32'd1);

  // wdog counts cycles spent waiting since the last sign of life from the camera.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= 32'd0;
      err_timeout <= 1'b0;
    end else begin
      if (wdog_entry || href_rise || !wdog_zone)
        wdog <= 32'd0;
      else
        wdog <= wdog + 32'd1;

      if (start_accept)
        err_timeout <= 1'b0;
      else if (timeout_hit)
        err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 32'd0);
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_edge_frame_sched.sv
// Scoreboard bench for edge_frame_sched with an 8x4 frame and a 3-cycle flush delay;
// the watchdog scenario runs only when EDGE_FRAME_SCHED_TIMEOUT_EN is defined.
module tb_edge_frame_sched;

  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_abort;
  logic       cfg_continuous;
  logic       in_vsync;
  logic       in_href;
  logic [7:0] in_gray;
  logic       out_vsync;
  logic       out_href;
  logic [7:0] out_gray;
  logic       flush_href;
  logic       busy;
  logic       done;
  logic       err_hlen;
  logic       err_vlen;
  logic       err_timeout;

  typedef struct {
    int         cyc;
    logic [7:0] gray;
  } pix_t;

  pix_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int href_cnt, flush_len, flush_runs, flush_start, done_cnt, done_cyc;
  int last_fall, last_vfall;
  logic flush_prev = 1'b0;

  edge_frame_sched #(
    .IMG_HDISP  (16'd8),
    .IMG_VDISP  (16'd4),
    .DELAY_NUM  (16'd3),
    .TIMEOUT_CYC(32'd100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_continuous(cfg_continuous),
    .in_vsync      (in_vsync),
    .in_href       (in_href),
    .in_gray       (in_gray),
    .out_vsync     (out_vsync),
    .out_href      (out_href),
    .out_gray      (out_gray),
    .flush_href    (flush_href),
    .busy          (busy),
    .done          (done),
    .err_hlen      (err_hlen),
    .err_vlen      (err_vlen),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Output monitor: pixels are popped from the scoreboard, flush/done timing is recorded.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_href) begin
        href_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("href_unexpected", 32'd1, 32'd0);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          checkOutput("pix_gray", {24'd0, out_gray}, {24'd0, e.gray});
          checkOutput("pix_cycle", cyc, e.cyc);
        end
      end
      if (flush_href) begin
        if (!flush_prev) begin
          flush_start = cyc;
          flush_runs++;
        end
        flush_len++;
      end
      flush_prev = flush_href;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearTally();
    href_cnt    = 0;
    flush_len   = 0;
    flush_runs  = 0;
    flush_start = -1;
    done_cnt    = 0;
    done_cyc    = -1;
  endtask

  task automatic pulseStart();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic pulseAbort();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n0;
    int i;
    n0 = done_cnt;
    i  = 0;
    while (done_cnt == n0 && i < budget) begin
      tick();
      i++;
    end
    if (done_cnt == n0) checkOutput("done_wait_expired", 32'd0, 32'd1);
  endtask

  // One camera frame: vsync high, 2 porch cycles, nlines lines (one optionally shortened), vsync low.
  task automatic applyStimulus(input int nlines, input int short_line, input int short_len,
                               input bit pass, input bit arm_mid);
    in_vsync = 1'b1;
    tick();
    if (arm_mid) cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      int np;
      np = (l == short_line) ? short_len : H;
      for (int p = 0; p < np; p++) begin
        pix_t e;
        in_href = 1'b1;
        in_gray = 8'($urandom_range(0, 255));
        if (pass) begin
          e.cyc  = cyc + 1;
          e.gray = in_gray;
          exp_q.push_back(e);
        end
        tick();
      end
      in_href   = 1'b0;
      last_fall = cyc;
      tick();
      tick();
    end
    in_vsync   = 1'b0;
    last_vfall = cyc;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst            = 1'b1;
    cfg_start      = 1'b0;
    cfg_abort      = 1'b0;
    cfg_continuous = 1'b0;
    in_vsync       = 1'b0;
    in_href        = 1'b0;
    in_gray        = 8'hA5;
    clearTally();
    repeat (3) tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_out_href", {31'd0, out_href}, 32'd0);
    checkOutput("rst_out_vsync", {31'd0, out_vsync}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush_href}, 32'd0);
    checkOutput("rst_gray", {24'd0, out_gray}, 32'd0);
    checkOutput("rst_errs", {29'd0, err_hlen, err_vlen, err_timeout}, 32'd0);
    rst     = 1'b0;
    in_gray = 8'd0;
    tick();

    // Nominal frame
    $display("[TB] nominal frame");
    clearTally();
    pulseStart();
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    applyStimulus(V, -1, 0, 1'b1, 1'b0);
    waitDone(60);
    checkOutput("nom_href_cnt", href_cnt, H * V);
    checkOutput("nom_flush_start", flush_start, last_fall + D + 1);
    checkOutput("nom_flush_len", flush_len, H);
    checkOutput("nom_done_cyc", done_cyc, last_fall + D + H + 1);
    checkOutput("nom_done_cnt", done_cnt, 1);
    checkOutput("nom_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("nom_errs", {29'd0, err_hlen, err_vlen, err_timeout}, 32'd0);
    tick();
    checkOutput("nom_vsync_low", {31'd0, out_vsync}, 32'd0);

    // Armed mid-frame: that frame is skipped, the next passes complete
    $display("[TB] armed mid-frame");
    clearTally();
    applyStimulus(V, -1, 0, 1'b0, 1'b1);
    checkOutput("mid_skip_href", href_cnt, 0);
    checkOutput("mid_wait_busy", {31'd0, busy}, 32'd1);
    tick();
    applyStimulus(V, -1, 0, 1'b1, 1'b0);
    waitDone(60);
    checkOutput("mid_href_cnt", href_cnt, H * V);
    checkOutput("mid_done_cyc", done_cyc, last_fall + D + H + 1);
    checkOutput("mid_done_cnt", done_cnt, 1);

    // Line 2 with 7 pixels
    $display("[TB] short line");
    clearTally();
    pulseStart();
    applyStimulus(V, 1, 7, 1'b1, 1'b0);
    waitDone(60);
    checkOutput("hlen_err", {31'd0, err_hlen}, 32'd1);
    checkOutput("hlen_vlen", {31'd0, err_vlen}, 32'd0);
    checkOutput("hlen_flush_len", flush_len, H);
    checkOutput("hlen_done_cnt", done_cnt, 1);
    pulseStart();
    checkOutput("hlen_cleared", {31'd0, err_hlen}, 32'd0);
    pulseAbort();
    checkOutput("hlen_abort_busy", {31'd0, busy}, 32'd0);

    // Short frame: vsync falls after 2 lines
    $display("[TB] short frame");
    clearTally();
    pulseStart();
    applyStimulus(2, -1, 0, 1'b1, 1'b0);
    waitDone(60);
    checkOutput("vlen_err", {31'd0, err_vlen}, 32'd1);
    checkOutput("vlen_flush_start", flush_start, last_vfall + D + 1);
    checkOutput("vlen_flush_len", flush_len, H);
    checkOutput("vlen_done_cnt", done_cnt, 1);

    // Empty frame: straight to done, no flush
    $display("[TB] empty frame");
    clearTally();
    pulseStart();
    applyStimulus(0, -1, 0, 1'b1, 1'b0);
    waitDone(20);
    checkOutput("empty_done_cyc", done_cyc, last_vfall + 1);
    checkOutput("empty_flush_runs", flush_runs, 0);
    checkOutput("empty_vlen", {31'd0, err_vlen}, 32'd1);

    // Simultaneous start and abort in IDLE
    $display("[TB] start+abort");
    tick();
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    checkOutput("sa_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("sa_busy_hold", {31'd0, busy}, 32'd0);
    checkOutput("sa_err_kept", {31'd0, err_vlen}, 32'd1);

    // Abort on the third flush cycle
    $display("[TB] abort in flush");
    clearTally();
    pulseStart();
    checkOutput("abort_start_clears", {31'd0, err_vlen}, 32'd0);
    applyStimulus(V, -1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && cyc < last_fall + D + 3; i++) tick();
    pulseAbort();
    checkOutput("abort_flush_off", {31'd0, flush_href}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_vsync", {31'd0, out_vsync}, 32'd0);
    repeat (15) tick();
    checkOutput("abort_flush_len", flush_len, 3);
    checkOutput("abort_no_done", done_cnt, 0);

    // Continuous mode over three frames
    $display("[TB] continuous");
    clearTally();
    cfg_continuous = 1'b1;
    pulseStart();
    for (int f = 0; f < 3; f++) begin
      applyStimulus(V, -1, 0, 1'b1, 1'b0);
      waitDone(60);
      checkOutput("cont_done_cyc", done_cyc, last_fall + D + H + 1);
      checkOutput("cont_rearmed", {31'd0, busy}, 32'd1);
      tick();
    end
    checkOutput("cont_done_cnt", done_cnt, 3);
    checkOutput("cont_href_cnt", href_cnt, 3 * H * V);
    cfg_continuous = 1'b0;
    pulseAbort();
    checkOutput("cont_abort_busy", {31'd0, busy}, 32'd0);

`ifdef EDGE_FRAME_SCHED_TIMEOUT_EN
    // Watchdog: no vsync after arming
    $display("[TB] watchdog");
    clearTally();
    pulseStart();
    repeat (90) tick();
    checkOutput("wd_still_busy", {31'd0, busy}, 32'd1);
    checkOutput("wd_not_yet", {31'd0, err_timeout}, 32'd0);
    repeat (15) tick();
    checkOutput("wd_err", {31'd0, err_timeout}, 32'd1);
    checkOutput("wd_idle", {31'd0, busy}, 32'd0);
    checkOutput("wd_no_done", done_cnt, 0);
`else
    checkOutput("timeout_tied", {31'd0, err_timeout}, 32'd0);
`endif

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
